// File: rtl/physical_register_free_list_pkg.sv
// Shared processor types for register renaming: the physical register
// index type, the commit-lane record and the architectural register count.
package processor_help;

  localparam int DEFAULT_SUPER_SCALAR_WIDTH          = 2;
  localparam int DEFAULT_PHYSICAL_REGISTER_FILE_SIZE = 64;
  localparam int ARCH_REGISTER_COUNT                 = 32;

  typedef logic [$clog2(DEFAULT_PHYSICAL_REGISTER_FILE_SIZE)-1:0] PhysicalRegister;

  // One retiring instruction with a destination; old_reg is the mapping it frees.
  typedef struct packed {
    logic            valid;
    PhysicalRegister old_reg;
  } FreeListCommit;

endpackage

// File: rtl/physical_register_free_list_lane_prefix_count.sv
// Exclusive prefix popcount across lanes: o_prefix[i] counts the set bits
// below lane i, and o_total counts all of them. Used to compact lanes.
module lane_prefix_count #(
  parameter  int WIDTH = 2,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_lanes,
  output logic [CW-1:0]    o_prefix [WIDTH],
  output logic [CW-1:0]    o_total
);

  // Running sum over the lanes in order.
  always_comb begin
    logic [CW-1:0] w_run;
    // NOTE: blocking assignments here so each lane sees the sum built so far.
    w_run = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_prefix[i] = w_run;
      w_run       = w_run + CW'(i_lanes[i]);
    end
    o_total = w_run;
  end

endmodule

// File: rtl/physical_register_free_list.sv
// Free list of physical registers. A circular buffer with a speculative
// allocation pointer (head), a committed allocation pointer (retired_head)
// and a push pointer (tail); each pointer carries one wrap bit so that a
// full buffer and an empty one are distinguishable. FREE_LIST_DEPTH must be
// a power of two so that pointer wrap is plain binary overflow.
module physical_register_free_list
  import processor_help::PhysicalRegister;
  import processor_help::FreeListCommit;
#(
  parameter int SUPER_SCALAR_WIDTH          = processor_help::DEFAULT_SUPER_SCALAR_WIDTH,
  parameter int PHYSICAL_REGISTER_FILE_SIZE = processor_help::DEFAULT_PHYSICAL_REGISTER_FILE_SIZE,
  parameter int ARCH_REGISTER_COUNT         = processor_help::ARCH_REGISTER_COUNT,
  parameter int FREE_LIST_DEPTH             = PHYSICAL_REGISTER_FILE_SIZE - ARCH_REGISTER_COUNT
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]      alloc_request_in,
  output logic                               alloc_ready_out,
  output PhysicalRegister                    alloc_reg_out [SUPER_SCALAR_WIDTH],
  input  FreeListCommit                      commit_in [SUPER_SCALAR_WIDTH],
  input  logic                               flush_in,
  output logic [$clog2(FREE_LIST_DEPTH):0]   free_count_out
);

  localparam int IW = $clog2(FREE_LIST_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(SUPER_SCALAR_WIDTH + 1);

  PhysicalRegister r_entries [FREE_LIST_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_retired_head;
  logic [PW-1:0]   r_tail;

  logic [SUPER_SCALAR_WIDTH-1:0] w_commit_valid;
  logic [CW-1:0]                 w_alloc_prefix  [SUPER_SCALAR_WIDTH];
  logic [CW-1:0]                 w_alloc_total;
  logic [CW-1:0]                 w_commit_prefix [SUPER_SCALAR_WIDTH];
  logic [CW-1:0]                 w_commit_total;
  logic [PW-1:0]                 w_free_count;
  logic [PW-1:0]                 w_retired_next;

  lane_prefix_count #(.WIDTH(SUPER_SCALAR_WIDTH)) u_alloc_count (
    .i_lanes  (alloc_request_in),
    .o_prefix (w_alloc_prefix),
    .o_total  (w_alloc_total)
  );

  lane_prefix_count #(.WIDTH(SUPER_SCALAR_WIDTH)) u_commit_count (
    .i_lanes  (w_commit_valid),
    .o_prefix (w_commit_prefix),
    .o_total  (w_commit_total)
  );

  assign w_free_count    = r_tail - r_head;
  assign w_retired_next  = r_retired_head + PW'(w_commit_total);
  assign free_count_out  = w_free_count;
  // Readiness looks only at stored state and flush, never at the requests.
  assign alloc_ready_out = (w_free_count >= PW'(SUPER_SCALAR_WIDTH)) && !flush_in;

  // Gather commit valids and pick each lane's granted register: requesting
  // lanes are packed onto consecutive entries, idle lanes show their own slot.
  always_comb begin
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      w_commit_valid[i] = commit_in[i].valid;
      if (alloc_request_in[i]) begin
        alloc_reg_out[i] = r_entries[r_head[IW-1:0] + IW'(w_alloc_prefix[i])];
      end else begin
        alloc_reg_out[i] = r_entries[r_head[IW-1:0] + IW'(i)];
      end
    end
  end

  // Pointer and buffer update: commits push at tail, allocation or flush
  // moves head; reset overrides everything in the same cycle.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every update sees pre-edge state.
    if (rst_in) begin
      // NOTE: the buffer itself is reset because its reset contents are the
      // initial set of free registers, not don't-care storage.
      for (int k = 0; k < FREE_LIST_DEPTH; k++) begin
        r_entries[k] <= PhysicalRegister'(ARCH_REGISTER_COUNT + k);
      end
      r_head         <= '0;
      r_retired_head <= '0;
      r_tail         <= PW'(FREE_LIST_DEPTH);
    end else begin
      for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
        if (commit_in[i].valid) begin
          r_entries[r_tail[IW-1:0] + IW'(w_commit_prefix[i])] <= commit_in[i].old_reg;
        end
      end
      r_tail         <= r_tail + PW'(w_commit_total);
      r_retired_head <= w_retired_next;
      if (flush_in) begin
        r_head <= w_retired_next;
      end else if (alloc_ready_out) begin
        r_head <= r_head + PW'(w_alloc_total);
      end
    end
  end

endmodule

// File: tb/tb_physical_register_free_list.sv
// Bench for physical_register_free_list. The reference model keeps the free
// registers as a queue starting at the oldest uncommitted allocation, plus a
// count of speculatively handed-out registers.
module tb_physical_register_free_list;
  import processor_help::*;

  localparam int W     = 2;
  localparam int DEPTH = 32;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [W-1:0]    alloc_request_in;
  logic            alloc_ready_out;
  PhysicalRegister alloc_reg_out [W];
  FreeListCommit   commit_in [W];
  logic            flush_in;
  logic [5:0]      free_count_out;

  int total = 0;
  int bad   = 0;

  PhysicalRegister m_q[$];
  int              m_out;

  physical_register_free_list dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .alloc_request_in (alloc_request_in),
    .alloc_ready_out  (alloc_ready_out),
    .alloc_reg_out    (alloc_reg_out),
    .commit_in        (commit_in),
    .flush_in         (flush_in),
    .free_count_out   (free_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_request_in  = '0;
    flush_in          = 1'b0;
    commit_in[0]      = '0;
    commit_in[1]      = '0;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < DEPTH; k++) m_q.push_back(PhysicalRegister'(ARCH_REGISTER_COUNT + k));
    m_out = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check outputs at the falling edge, step model.
  task automatic cycle(input string tag, input logic [1:0] req, input logic [1:0] cv,
                       input PhysicalRegister r0, input PhysicalRegister r1, input logic fl);
    logic exp_ready;
    int   k;
    int   n_commit;
    alloc_request_in     = req;
    commit_in[0].valid   = cv[0];
    commit_in[0].old_reg = r0;
    commit_in[1].valid   = cv[1];
    commit_in[1].old_reg = r1;
    flush_in             = fl;
    #4;
    exp_ready = ((DEPTH - m_out) >= W) && !fl;
    check({tag, ":ready"}, 32'(alloc_ready_out), 32'(exp_ready));
    check({tag, ":free"}, 32'(free_count_out), 32'(DEPTH - m_out));
    k = 0;
    if (exp_ready) begin
      for (int i = 0; i < W; i++) begin
        if (req[i]) begin
          check($sformatf("%s:lane%0d", tag, i), 32'(alloc_reg_out[i]), 32'(m_q[m_out + k]));
          k++;
        end
      end
    end
    n_commit = 0;
    if (cv[0]) begin m_q.push_back(r0); n_commit++; end
    if (cv[1]) begin m_q.push_back(r1); n_commit++; end
    repeat (n_commit) void'(m_q.pop_front());
    m_out = fl ? 0 : (m_out + k - n_commit);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [1:0]      rq;
    logic [1:0]      cv;
    int              room;
    idle_inputs();
    rst_in = 1'b1;

    // Reset state.
    do_reset();
    check("rst:free", 32'(free_count_out), 32);
    check("rst:ready", 32'(alloc_ready_out), 1);
    check("rst:reg0", 32'(alloc_reg_out[0]), 32);
    check("rst:reg1", 32'(alloc_reg_out[1]), 33);

    // Full-width allocation.
    alloc_request_in = 2'b11;
    #1;
    check("full:c0reg0", 32'(alloc_reg_out[0]), 32);
    check("full:c0reg1", 32'(alloc_reg_out[1]), 33);
    cycle("full0", 2'b11, 2'b00, '0, '0, 1'b0);
    check("full:free30", 32'(free_count_out), 30);
    check("full:c1reg0", 32'(alloc_reg_out[0]), 34);
    check("full:c1reg1", 32'(alloc_reg_out[1]), 35);
    cycle("full1", 2'b11, 2'b00, '0, '0, 1'b0);
    check("full:free28", 32'(free_count_out), 28);

    // Sparse request compaction.
    do_reset();
    alloc_request_in = 2'b10;
    #1;
    check("sparse:lane1", 32'(alloc_reg_out[1]), 32);
    cycle("sparse0", 2'b10, 2'b00, '0, '0, 1'b0);
    alloc_request_in = 2'b01;
    #1;
    check("sparse:lane0", 32'(alloc_reg_out[0]), 33);
    cycle("sparse1", 2'b01, 2'b00, '0, '0, 1'b0);

    // Exhaustion: 31 allocated, then held requests change nothing.
    do_reset();
    for (int c = 0; c < 15; c++) cycle("exh", 2'b11, 2'b00, '0, '0, 1'b0);
    cycle("exh_last", 2'b01, 2'b00, '0, '0, 1'b0);
    check("exh:free1", 32'(free_count_out), 1);
    check("exh:notready", 32'(alloc_ready_out), 0);
    for (int c = 0; c < 3; c++) cycle("exh_hold", 2'b11, 2'b00, '0, '0, 1'b0);
    check("exh:hold_free", 32'(free_count_out), 1);

    // Commit then allocate: 5 comes right after the remaining entry 63.
    cycle("cmt", 2'b00, 2'b01, 6'd5, '0, 1'b0);
    check("cmt:free2", 32'(free_count_out), 2);
    alloc_request_in = 2'b11;
    #1;
    check("cmt:reg0", 32'(alloc_reg_out[0]), 63);
    check("cmt:reg1", 32'(alloc_reg_out[1]), 5);
    cycle("cmt_alloc", 2'b11, 2'b00, '0, '0, 1'b0);

    // Flush with a concurrent commit.
    do_reset();
    for (int c = 0; c < 3; c++) cycle("fl_alloc", 2'b11, 2'b00, '0, '0, 1'b0);
    cycle("fl_c7", 2'b00, 2'b10, '0, 6'd7, 1'b0);
    cycle("fl_c9", 2'b00, 2'b10, '0, 6'd9, 1'b0);
    flush_in = 1'b1;
    #1;
    check("fl:ready_low", 32'(alloc_ready_out), 0);
    cycle("fl_flush", 2'b11, 2'b01, 6'd11, '0, 1'b0 | 1'b1);
    check("fl:free32", 32'(free_count_out), 32);
    alloc_request_in = 2'b11;
    #1;
    check("fl:reg0", 32'(alloc_reg_out[0]), 35);
    check("fl:reg1", 32'(alloc_reg_out[1]), 36);
    cycle("fl_after", 2'b11, 2'b00, '0, '0, 1'b0);

    // Random traffic long enough to wrap every pointer.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      rq   = 2'($urandom);
      cv   = 2'($urandom);
      room = m_out;
      if (cv[0] && room > 0) room--; else cv[0] = 1'b0;
      if (cv[1] && room > 0) room--; else cv[1] = 1'b0;
      cycle($sformatf("rnd%0d", c), rq, cv, PhysicalRegister'($urandom),
            PhysicalRegister'($urandom), ($urandom_range(15) == 0));
      check("rnd:invariant", 32'(free_count_out <= 6'(DEPTH)), 1);
    end

    // Reset asserted with traffic active overrides everything.
    alloc_request_in   = 2'b11;
    commit_in[0].valid = 1'b1;
    commit_in[1].valid = 1'b1;
    flush_in           = 1'b1;
    rst_in             = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("mid:free", 32'(free_count_out), 32);
    check("mid:ready", 32'(alloc_ready_out), 1);
    check("mid:reg0", 32'(alloc_reg_out[0]), 32);
    check("mid:reg1", 32'(alloc_reg_out[1]), 33);
    cycle("mid_a0", 2'b11, 2'b00, '0, '0, 1'b0);
    cycle("mid_a1", 2'b11, 2'b00, '0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/physical_register_free_list.md
# physical_register_free_list

Tracks which physical registers are unmapped and hands them to the rename stage, up to SUPER_SCALAR_WIDTH per cycle. Registers whose old mappings retire are returned at commit, and all speculative allocations are recovered in one cycle on a pipeline flush. The block sits between rename, commit and the flush logic. It is the sole owner of physical-register allocation for physical_register_file.

## Interface
Parameters:
- SUPER_SCALAR_WIDTH, from processor_help: lanes per cycle for allocation and commit.
- PHYSICAL_REGISTER_FILE_SIZE, from processor_help: total physical registers.
- ARCH_REGISTER_COUNT, 32: architectural registers, each permanently holding one mapping.
- FREE_LIST_DEPTH, PHYSICAL_REGISTER_FILE_SIZE - ARCH_REGISTER_COUNT: must be a power of two.

Ports:
- clk_in  input  1  clock. One clock; all state changes on posedge clk_in.
- rst_in  input  1  reset. Synchronous, active-high.
- alloc_request_in  input  [SUPER_SCALAR_WIDTH-1:0]  lane i wants a destination register this cycle.
- alloc_ready_out  output  1  at least SUPER_SCALAR_WIDTH free entries available, and no flush this cycle.
- alloc_reg_out  output  PhysicalRegister[SUPER_SCALAR_WIDTH]  register granted to lane i. Meaningful only when alloc_request_in[i] and alloc_ready_out are both high.
- commit_in  input  FreeListCommit[SUPER_SCALAR_WIDTH]  {valid, old_reg}: a retiring instruction with a destination; old_reg is its previous mapping.
- flush_in  input  1  discard all uncommitted allocations.
- free_count_out  output  $clog2(FREE_LIST_DEPTH)+1  speculative free entries (tail − head).

## Operation
- **Storage:** circular buffer of FREE_LIST_DEPTH PhysicalRegister entries. It has three pointers, each with one extra wrap bit:
  - head: speculative allocation point.
  - retired_head: committed allocation point.
  - tail: push point.
- **Reset:** entry k = ARCH_REGISTER_COUNT + k; head = retired_head = 0; tail = FREE_LIST_DEPTH.
  - free_count_out = FREE_LIST_DEPTH; alloc_ready_out = 1; alloc_reg_out[i] = ARCH_REGISTER_COUNT + i.
- **Allocation:** a transfer happens when alloc_ready_out is high. Handshake is all-or-nothing per cycle.
  - Requesting lanes are compacted: lane i receives entry[head + popcount(alloc_request_in[i-1:0])].
  - head advances by popcount(alloc_request_in).
  - Non-requesting lanes still drive alloc_reg_out with their slot value. Consumers ignore it.
  - Requests made while alloc_ready_out is low are not granted and have no effect. Rename stalls.
- **Commit:** valid lanes are compacted in lane order.
  - Lane i's old_reg is written to entry[tail + popcount(valid[i-1:0])].
  - tail and retired_head each advance by popcount(valid).
- **Flush:** head <= retired_head after this cycle's commit advance. Commits presented in the flush cycle are honoured.
  - alloc_ready_out is forced low during flush_in, so no allocation occurs.
- **Simultaneous alloc + commit:** both apply. Registers pushed in cycle N are allocatable from cycle N+1, never in cycle N.
- **Wrap-around:** all indices are taken modulo FREE_LIST_DEPTH. Full and empty are distinguished by the wrap bit.
- **Invariant:** tail − retired_head ≤ FREE_LIST_DEPTH. Physical registers are conserved, so the list cannot overflow. Verification asserts this. There is no back-pressure on commit.
- **x0 handling:** rename never requests a register for rd = x0, and commit never frees for x0. The block does not special-case x0.

## Timing
- alloc_ready_out, alloc_reg_out and free_count_out are combinational from registered state and flush_in. There is no dependency on alloc_request_in, so no combinational loop through rename.
- Allocation latency is 0 cycles: grant in the same cycle as the request.
- Commit-to-available latency is 1 cycle.
- Flush recovery is 1 cycle: the cycle after flush_in, free_count_out = tail − retired_head.
- If reset is asserted mid-operation it overrides flush, commit and alloc in the same cycle. The next cycle matches the reset state exactly.

## Structure
- **In processor_help:**
  - typedef PhysicalRegister = logic[$clog2(PHYSICAL_REGISTER_FILE_SIZE)-1:0].
  - struct FreeListCommit {valid; PhysicalRegister old_reg}.
  - constant ARCH_REGISTER_COUNT.
- **Sub-module lane_prefix_count:** combinational exclusive prefix popcount over a SUPER_SCALAR_WIDTH-bit vector, plus the total count. One instance for allocation and one for commit.

## Test plan
All scenarios use SUPER_SCALAR_WIDTH = 2 and PHYSICAL_REGISTER_FILE_SIZE = 64 (FREE_LIST_DEPTH = 32).
- **Reset then full allocation:** alloc_request_in = 2'b11 → regs 32, 33; next cycle 34, 35; free_count_out goes 32 → 30 → 28.
- **Sparse request:** alloc_request_in = 2'b10 → lane 1 gets 32; next cycle's lane 0 gets 33.
- **Exhaustion:** allocate 31 registers → free_count_out = 1, alloc_ready_out = 0. Request held for 3 cycles → no change.
- **Commit then allocate:** commit lane 0 with old_reg = 5 in cycle N → free_count_out +1 in N+1; the entry after the pre-existing ones allocates 5.
- **Flush with concurrent commit:** allocate 6, commit 2 (lane 1 only, old_reg 7 and 9 over two cycles), then flush with one commit (old_reg 11). Next cycle free_count_out = 32 − 3 + 3 = 32, and the allocation order continues from the fourth entry.
- **Wrap-around and reset mid-stream:** run 100 random alloc/commit cycles → pointers wrap and the invariant holds. Assert rst_in with requests active → next-cycle state equals reset state.
